// File: rtl/axi4_lite_read_slave.sv
// AXI4-Lite read responder over a word-addressed memory with a fixed,
// parameterised response latency. Out-of-range reads return DECERR.
// The backdoor port preloads or patches the array at any time.
module axi4_lite_read_slave #(
  parameter int          ADDR_W  = 64,
  parameter int          DATA_W  = 64,
  parameter int          DEPTH   = 1024,
  parameter logic [63:0] BASE    = 64'h8000_0000,
  parameter int          LATENCY = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ADDR_W-1:0]        AR_ADDR,
  input  logic                     AR_VALID,
  input  logic [2:0]               AR_PROT,
  output logic                     AR_READY,
  output logic [DATA_W-1:0]        R_DATA,
  output logic [1:0]               R_RESP,
  output logic                     R_VALID,
  input  logic                     R_READY,
  input  logic                     mem_we,
  input  logic [$clog2(DEPTH)-1:0] mem_waddr,
  input  logic [DATA_W-1:0]        mem_wdata
);
  localparam int                BYTES  = DATA_W / 8;
  localparam int                OFF_W  = $clog2(BYTES);
  localparam int                IDX_W  = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] BASE_A = BASE[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] SPAN   = ADDR_W'(DEPTH * BYTES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e              state_q;
  logic [3:0]          cnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                ar_ready_q;
  logic                r_valid_q;
  logic [DATA_W-1:0]   r_data_q;
  logic [1:0]          r_resp_q;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic [ADDR_W-1:0]   lk_addr;
  logic [ADDR_W-1:0]   off;
  logic                in_rng;
  logic [DATA_W-1:0]   r_data_d;
  logic [1:0]          r_resp_d;

  // Protection bits carry no meaning for this memory.
  logic unused_prot;
  assign unused_prot = ^AR_PROT;

  assign AR_READY = ar_ready_q;
  assign R_VALID  = r_valid_q;
  assign R_DATA   = r_data_q;
  assign R_RESP   = r_resp_q;

  // Response lookup. With zero latency the response is captured on the AR
  // handshake edge itself, so the live address is used while IDLE.
  always_comb begin
    lk_addr  = (state_q == IDLE) ? AR_ADDR : addr_q;
    off      = lk_addr - BASE_A;
    in_rng   = (lk_addr >= BASE_A) && (off < SPAN);
    r_data_d = '0;
    r_resp_d = 2'b11;
    if (in_rng) begin
      r_data_d = mem[off[OFF_W+IDX_W-1:OFF_W]];
      r_resp_d = 2'b00;
    end
  end

  // Backdoor write; a write on the response capture edge lands after the read.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Read FSM: accept one address, wait out the latency, hold the response
  // until the master takes it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      ar_ready_q <= 1'b0;
      r_valid_q  <= 1'b0;
      r_data_q   <= '0;
      r_resp_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (AR_VALID && ar_ready_q) begin
            ar_ready_q <= 1'b0;
            addr_q     <= AR_ADDR;
            if (LATENCY == 0) begin
              state_q   <= RESP;
              r_valid_q <= 1'b1;
              r_data_q  <= r_data_d;
              r_resp_q  <= r_resp_d;
            end else begin
              state_q <= WAIT;
              cnt_q   <= 4'(LATENCY);
            end
          end else begin
            ar_ready_q <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt_q == 4'd1) begin
            state_q   <= RESP;
            r_valid_q <= 1'b1;
            r_data_q  <= r_data_d;
            r_resp_q  <= r_resp_d;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (R_READY) begin
            state_q    <= IDLE;
            r_valid_q  <= 1'b0;
            ar_ready_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi4_lite_read_slave.sv
// Bench for axi4_lite_read_slave: two instances (LATENCY 0 and 2) share the
// backdoor port; a cycle-based reference model predicts latency, data,
// decode errors and hold behaviour.
module tb_axi4_lite_read_slave;
  localparam logic [63:0] BASE  = 64'h8000_0000;
  localparam int          DEPTH = 1024;
  localparam logic [63:0] SPAN  = 64'(DEPTH * 8);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] ar_addr  [2];
  logic        ar_valid [2];
  logic [2:0]  ar_prot  [2];
  logic        ar_ready [2];
  logic [63:0] r_data   [2];
  logic [1:0]  r_resp   [2];
  logic        r_valid  [2];
  logic        r_ready  [2];
  logic        mem_we;
  logic [9:0]  mem_waddr;
  logic [63:0] mem_wdata;

  logic [63:0] ref_mem [DEPTH];
  logic [63:0] tbq [$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  axi4_lite_read_slave #(.LATENCY(0)) u_l0 (
    .clk(clk), .rst_n(rst_n),
    .AR_ADDR(ar_addr[0]), .AR_VALID(ar_valid[0]), .AR_PROT(ar_prot[0]), .AR_READY(ar_ready[0]),
    .R_DATA(r_data[0]), .R_RESP(r_resp[0]), .R_VALID(r_valid[0]), .R_READY(r_ready[0]),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
  );

  axi4_lite_read_slave #(.LATENCY(2)) u_l2 (
    .clk(clk), .rst_n(rst_n),
    .AR_ADDR(ar_addr[1]), .AR_VALID(ar_valid[1]), .AR_PROT(ar_prot[1]), .AR_READY(ar_ready[1]),
    .R_DATA(r_data[1]), .R_RESP(r_resp[1]), .R_VALID(r_valid[1]), .R_READY(r_ready[1]),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // {resp, data} a correct slave returns for byte address a.
  function automatic logic [65:0] model(input logic [63:0] a);
    if (a >= BASE && (a - BASE) < SPAN) return {2'b00, ref_mem[10'((a - BASE) >> 3)]};
    return {2'b11, 64'h0};
  endfunction

  function automatic logic [63:0] rnd_addr();
    case ($urandom_range(0, 5))
      0:       return BASE - 64'(8 * $urandom_range(1, 4));
      1:       return BASE + SPAN + 64'($urandom_range(0, 15));
      2:       return BASE + SPAN - 64'($urandom_range(1, 8));
      default: return BASE + 64'($urandom_range(0, DEPTH * 8 - 1));
    endcase
  endfunction

  task automatic bd_write(input int idx, input logic [63:0] d);
    mem_we    = 1'b1;
    mem_waddr = 10'(idx);
    mem_wdata = d;
    ref_mem[idx] = d;
    @(posedge clk); #1;
    mem_we = 1'b0;
  endtask

  // Drive instance k for ncyc cycles (then drain). Addresses come from tbq
  // first, else randomly if rnd. b2b: R_READY tied high, period checked.
  // stall: R_READY held low for 5 cycles of every response.
  task automatic run(input int k, input int ncyc, input bit b2b, input bit stall, input bit rnd);
    int          L = (k == 0) ? 0 : 2;
    bit          out = 1'b0;
    int          acc_i = 0;
    int          last_hs = -1;
    logic [63:0] a = '0;
    logic [65:0] exp = '0;
    bit          prev_v = 1'b0;
    logic [63:0] prev_d = '0;
    logic [1:0]  prev_r = '0;
    bit          ahs, rhs;
    int          i = 0;
    while (1) begin
      if (i >= ncyc && !out && !ar_valid[k] && tbq.size() == 0) break;
      if (i >= ncyc + 300) begin
        chk("drain_timeout", 64'(i), 64'(ncyc));
        break;
      end
      if (prev_v) begin
        chk("r_valid_hold", 64'(r_valid[k]), 64'd1);
        chk("r_data_hold", r_data[k], prev_d);
        chk("r_resp_hold", 64'(r_resp[k]), 64'(prev_r));
      end
      if (out) begin
        if (i < acc_i + 1 + L)       chk("r_valid_early", 64'(r_valid[k]), 64'd0);
        else if (i == acc_i + 1 + L) chk("r_valid_latency", 64'(r_valid[k]), 64'd1);
        chk("ar_ready_busy", 64'(ar_ready[k]), 64'd0);
      end else begin
        chk("r_valid_idle", 64'(r_valid[k]), 64'd0);
        chk("ar_ready_idle", 64'(ar_ready[k]), 64'd1);
      end
      if (b2b)        r_ready[k] = 1'b1;
      else if (stall) r_ready[k] = out && (i >= acc_i + L + 6);
      else            r_ready[k] = 1'($urandom_range(0, 1));
      rhs = r_valid[k] && r_ready[k];
      if (rhs) begin
        chk("r_data", r_data[k], exp[63:0]);
        chk("r_resp", 64'(r_resp[k]), 64'(exp[65:64]));
        out = 1'b0;
      end
      if (!ar_valid[k]) begin
        if (tbq.size() > 0) begin
          ar_addr[k]  = tbq.pop_front();
          ar_valid[k] = 1'b1;
        end else if (rnd && i < ncyc && $urandom_range(0, 2) == 0) begin
          ar_addr[k]  = rnd_addr();
          ar_valid[k] = 1'b1;
        end
        ar_prot[k] = 3'($urandom_range(0, 7));
      end
      ahs = ar_valid[k] && ar_ready[k];
      if (ahs) begin
        if (b2b && last_hs >= 0) chk("b2b_period", 64'(i - last_hs), 64'(L + 2));
        last_hs = i;
        out     = 1'b1;
        acc_i   = i;
        a       = ar_addr[k];
      end
      // The response is captured on the edge after iteration acc_i+L,
      // before any write driven in that same iteration lands.
      if (out && i == acc_i + L) exp = model(a);
      mem_we = 1'b0;
      if (rnd && $urandom_range(0, 3) == 0) begin
        mem_we    = 1'b1;
        mem_waddr = $urandom_range(0, 1) ? 10'((a - BASE) >> 3) : 10'($urandom_range(0, DEPTH - 1));
        mem_wdata = {$urandom, $urandom};
        ref_mem[mem_waddr] = mem_wdata;
      end
      prev_v = r_valid[k] && !rhs;
      prev_d = r_data[k];
      prev_r = r_resp[k];
      @(posedge clk); #1;
      mem_we = 1'b0;
      if (ahs) ar_valid[k] = 1'b0;
      i++;
    end
    r_ready[k] = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      ar_addr[k] = '0; ar_valid[k] = 1'b0; ar_prot[k] = '0; r_ready[k] = 1'b0;
    end
    mem_we = 1'b0; mem_waddr = '0; mem_wdata = '0;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_ar_ready", 64'(ar_ready[k]), 64'd0);
      chk("rst_r_valid", 64'(r_valid[k]), 64'd0);
      chk("rst_r_data", r_data[k], 64'd0);
      chk("rst_r_resp", 64'(r_resp[k]), 64'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) chk("ar_ready_after_rst", 64'(ar_ready[k]), 64'd1);

    // Preload the whole array
    for (int w = 0; w < DEPTH; w++)
      bd_write(w, (w == 0) ? 64'hDEAD_BEEF_0123_4567 : {$urandom, $urandom});

    // Directed addresses: base, byte offset, next word, just past top, top word, below base
    for (int k = 1; k >= 0; k--) begin
      tbq = '{BASE, BASE + 64'h7, BASE + 64'h8, BASE + 64'h2000,
              BASE + SPAN - 64'h8, BASE + SPAN - 64'h1, BASE - 64'h8};
      run(k, 1, 1'b1, 1'b0, 1'b0);
    end

    // Back-to-back words 0..7
    for (int k = 0; k < 2; k++) begin
      for (int w = 0; w < 8; w++) tbq.push_back(BASE + 64'(8 * w));
      run(k, 1, 1'b1, 1'b0, 1'b0);
    end

    // Response stalled 5 cycles with competing AR requests
    for (int k = 0; k < 2; k++) run(k, 80, 1'b0, 1'b1, 1'b1);

    // Reset pulse while in WAIT aborts the read
    r_ready[1]  = 1'b1;
    ar_addr[1]  = BASE;
    ar_valid[1] = 1'b1;
    chk("rstw_ar_ready_pre", 64'(ar_ready[1]), 64'd1);
    @(posedge clk); #1;
    ar_valid[1] = 1'b0;
    chk("rstw_r_valid_wait", 64'(r_valid[1]), 64'd0);
    rst_n = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      chk("rstw_ar_ready_low", 64'(ar_ready[1]), 64'd0);
      chk("rstw_r_valid_low", 64'(r_valid[1]), 64'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rstw_ar_ready_up", 64'(ar_ready[1]), 64'd1);
    repeat (4) begin
      chk("rstw_no_resp", 64'(r_valid[1]), 64'd0);
      @(posedge clk); #1;
    end
    r_ready[1] = 1'b0;
    tbq = '{BASE};
    run(1, 1, 1'b1, 1'b0, 1'b0);

    // Random traffic with concurrent backdoor writes
    for (int k = 0; k < 2; k++) run(k, 2000, 1'b0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi4_lite_read_slave.md
# axi4_lite_read_slave

AXI4-Lite read-channel responder backed by a word-addressed memory with programmable response latency. It is the slave end for the NPC's AXI4-Lite read masters, such as instruction fetch and LSU loads, and models SRAM-like read timing. A backdoor write port lets the bench and the boot loader preload the array. Out-of-range accesses return a decode error instead of aliasing.

## Interface
- ADDR_W, 64, address width
- DATA_W, 64, data width; word = DATA_W/8 bytes, DATA_W ∈ {32, 64}
- DEPTH, 1024, memory words (power of two)
- BASE, 64'h8000_0000, byte address of word 0
- LATENCY, 2, idle cycles between AR handshake and R_VALID (0..15)
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- AR_ADDR  in  ADDR_W  read byte address
- AR_VALID  in  1  address valid
- AR_PROT  in  3  ignored
- AR_READY  out  1  address accepted
- R_DATA  out  DATA_W  read data
- R_RESP  out  2  2'b00 OKAY, 2'b11 DECERR
- R_VALID  out  1  response valid
- R_READY  in  1  master accepts response
- mem_we  in  1  backdoor write enable
- mem_waddr  in  $clog2(DEPTH)  backdoor word index
- mem_wdata  in  DATA_W  backdoor write data

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - AR_READY=1.
  - On AR_VALID&AR_READY, register AR_ADDR.
  - Load the latency counter with LATENCY.
  - Go to WAIT if LATENCY>0, else RESP.
- WAIT:
  - AR_READY=0, R_VALID=0.
  - Decrement the counter each cycle.
  - Move to RESP on the cycle the counter reaches 1.
- RESP entry edge: R_DATA and R_RESP are registered from the latched address.
  - In range means BASE ≤ addr < BASE+DEPTH·(DATA_W/8).
  - In range: index = (addr−BASE) >> log2(DATA_W/8); low byte-offset bits are ignored; R_DATA=mem[index], R_RESP=2'b00.
  - Out of range: R_DATA=0, R_RESP=2'b11.
- RESP:
  - R_VALID=1.
  - R_DATA and R_RESP are held stable until R_VALID&R_READY.
  - Then return to IDLE.
- Only one outstanding transaction. AR_VALID asserted outside IDLE is not accepted; the master must hold it.
- Backdoor write:
  - mem[mem_waddr] <= mem_wdata on any edge with mem_we=1, in any state.
  - A write to the same word on the RESP entry edge is not visible; the old data is returned.
- AR_PROT is not decoded.

## Timing
- Reset (rst_n=0 at an edge):
  - State goes to IDLE.
  - AR_READY=0, R_VALID=0, R_DATA=0, R_RESP=0.
  - The counter clears; memory contents are not cleared.
- AR_READY rises on the first edge with rst_n=1.
- All outputs are registered; there is no combinational path from inputs to outputs.
- AR handshake at edge T gives R_VALID=1 from edge T+1+LATENCY.
- R handshake at edge U gives R_VALID=0 and AR_READY=1 from U+1.
- A new AR can therefore be accepted at U+1.
- Back-to-back throughput is one transaction per LATENCY+2 cycles with R_READY tied high.
- AR_READY drops on the edge after the handshake and stays low until the R handshake completes.
- R_VALID is never withdrawn without a handshake. R_READY may be high before R_VALID without effect.
- Reset mid-transaction (WAIT or RESP) aborts the transaction: no response is issued, and the state is IDLE after reset.
- The address check for an access ending exactly at the top word boundary is in range; one word past it is DECERR.

## Test plan
- Preload mem[0]=64'hDEAD_BEEF_0123_4567, LATENCY=2, R_READY=1, AR_ADDR=64'h8000_0000.
  - Required: R_VALID exactly 3 cycles after the handshake, R_DATA=64'hDEAD_BEEF_0123_4567, R_RESP=00.
- AR_ADDR=64'h8000_0007 with mem[0] preloaded.
  - Required: same data (offset ignored).
- AR_ADDR=64'h8000_0008 returns mem[1]. AR_ADDR=64'h8000_2000 (DEPTH=1024) returns R_RESP=11, R_DATA=0.
- R_READY held low for 5 cycles in RESP.
  - Required: R_VALID, R_DATA and R_RESP stable throughout; AR_READY=0; a second AR_VALID is not accepted.
  - After R_READY=1: AR_READY=1 next cycle.
- Parameter sweep:
  - LATENCY=0: R_VALID one cycle after the handshake.
  - Back-to-back reads to words 0..7 with R_READY=1: correct data; period of 2 cycles (LATENCY=0) and 4 cycles (LATENCY=2).
- Reset pulse during WAIT.
  - Required: R_VALID never asserts; AR_READY=0 during reset, 1 the cycle after; the next read returns the preloaded data unchanged.
